id_ex_stage: RTL
================

Name: id_ex_stage

Overview:
Decode-to-execute pipeline register feeding the ALU operand inputs (a, b, alu_control) of the 16-bit core. It captures decoded instructions through a valid/ready handshake and resolves RAW hazards. Operands are resolved before capture: EX/MEM forwarding, then immediate select, then a registered result. It also detects load-use hazards and inserts bubbles, and supports stall by the downstream stage and flush.

Parameters:
DW, 16, datapath width
RW, 3, register address width (8 registers; r0 hardwired zero)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high
in_valid  in  1  upstream instruction valid
in_ready  out  1  this stage accepts this cycle
in_rs  in  RW  source reg 1 index
in_rt  in  RW  source reg 2 index
in_rd  in  RW  destination index
in_rs_data  in  DW  regfile read of rs (write-through regfile)
in_rt_data  in  DW  regfile read of rt
in_imm  in  DW  sign-extended immediate
in_alu_control  in  3  ALU op code (000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT)
in_alu_src  in  1  1: B operand = imm
in_ctrl  in  4  {reg_write, mem_read, mem_write, mem_to_reg}
flush  in  1  kill held instruction
ex_ready  in  1  EX/downstream accepts out_* this cycle
ex_result  in  DW  ALU result of instruction currently on out_*
mem_reg_write  in  1  MEM-stage instruction writes a register
mem_rd  in  RW  MEM-stage destination
mem_data  in  DW  MEM-stage write-back value
out_valid  out  1  out_* hold a live instruction
out_a  out  DW  ALU operand a
out_b  out  DW  ALU operand b
out_alu_control  out  3  registered in_alu_control
out_store_data  out  DW  forwarded rt value for stores
out_rd  out  RW  registered destination
out_ctrl  out  4  registered in_ctrl

Behaviour:
- Reset: out_valid=0. All out_* data/ctrl=0. Reset has priority over flush and capture; it drops any held instruction.
- Two states. EMPTY (out_valid=0) and FULL (out_valid=1).
- Hazard: load_use = out_valid & out_ctrl[3] & out_ctrl[2] & out_rd!=0 & (out_rd==in_rs | out_rd==in_rt).
- in_ready = !flush & !load_use & (!out_valid | ex_ready). It is combinational and does not depend on in_valid.
- Capture = in_valid & in_ready. Next cycle out_valid=1 and all out_* take the resolved values. Latency is 1 cycle.
- FULL & !ex_ready & !flush: every out_* holds unchanged.
- Drain: ex_ready & !capture. out_valid<=0 next cycle (bubble). out_* data may hold but is don't-care.
- Load-use: with ex_ready=1, a bubble is inserted and the load advances. The next cycle re-evaluates with the load gone from out_*, and the dependent instruction is captured via MEM forwarding (mem_data).
- flush: out_valid<=0 next cycle and no capture. This overrides hold, ex_ready and in_valid.
- Forwarding per source X in {rs, rt}, first match wins:
  1. X==0 -> 0.
  2. out_valid & out_ctrl[3] & !out_ctrl[2] & out_rd==X -> ex_result.
  3. mem_reg_write & mem_rd==X -> mem_data.
  4. Otherwise, the regfile data.
- Operand assignment: out_a = fwd(rs). out_store_data = fwd(rt). out_b = in_alu_src ? in_imm : fwd(rt).
- Widths: all data is DW, with no extension or truncation. Comparisons are on the full RW bits.

Optional Feature:
ID_EX_STALL_CNT_EN:
- Defined: adds output port stall_count [15:0]. It is a saturating counter of cycles where in_valid & load_use & !flush. Reset sets it to 0, and it holds at 16'hFFFF once saturated.
- Undefined: the port and counter are absent, and all other behaviour is identical.

Test Plan:
- Reset, then in_valid=1, rs=1 (data 5), rt=2 (data 7), ALU 010, alu_src=0, ex_ready=1 -> next cycle out_valid=1, out_a=5, out_b=7, out_alu_control=010.
- FULL with out_rd=3, reg_write=1, ex_result=16'h0010. Next instruction has rs=3 and mem_rd=3, mem_data=16'h0020 -> out_a=16'h0010 (EX priority over MEM).
- Load to r4 on out_* (mem_read=1). Incoming rs=4 -> in_ready=0, then a bubble (out_valid=0). Next cycle, with mem_rd=4, mem_data=16'h1234 -> capture with out_a=16'h1234.
- FULL and ex_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and out_* constant. Raising ex_ready captures the new instruction on that edge.
- Forward with rs=0 while ex/mem target r0 with data 16'hFFFF -> out_a=0. Then alu_src=1, imm=16'hFFFC -> out_b=16'hFFFC and out_store_data=fwd(rt).
- flush=1 with in_valid=1 while FULL -> in_ready=0 and out_valid=0 next cycle. Reset asserted mid-hold -> all outputs 0 next cycle.

Source files
------------

// File: rtl/id_ex_stage.sv
// id_ex_stage: decode-to-execute pipeline register for the 16-bit core.
// Resolves ALU operands (EX/MEM forwarding, immediate select) before capture,
// detects load-use hazards and inserts bubbles, and supports downstream stall
// and flush through a valid/ready handshake.
//
// Optional feature (define ID_EX_STALL_CNT_EN): adds output stall_count, a
// saturating count of cycles an incoming instruction waits on a load-use hazard.
module id_ex_stage #(
  parameter int DW = 16,
  parameter int RW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [RW-1:0] in_rs,
  input  logic [RW-1:0] in_rt,
  input  logic [RW-1:0] in_rd,
  input  logic [DW-1:0] in_rs_data,
  input  logic [DW-1:0] in_rt_data,
  input  logic [DW-1:0] in_imm,
  input  logic [2:0]    in_alu_control,
  input  logic          in_alu_src,
  input  logic [3:0]    in_ctrl,
  input  logic          flush,
  input  logic          ex_ready,
  input  logic [DW-1:0] ex_result,
  input  logic          mem_reg_write,
  input  logic [RW-1:0] mem_rd,
  input  logic [DW-1:0] mem_data,
  output logic          out_valid,
  output logic [DW-1:0] out_a,
  output logic [DW-1:0] out_b,
  output logic [2:0]    out_alu_control,
  output logic [DW-1:0] out_store_data,
  output logic [RW-1:0] out_rd,
  output logic [3:0]    out_ctrl
`ifdef ID_EX_STALL_CNT_EN
  ,
  output logic [15:0]   stall_count
`endif
);

  // out_ctrl bit positions: {reg_write, mem_read, mem_write, mem_to_reg}
  localparam int CTRL_REG_WRITE = 3;
  localparam int CTRL_MEM_READ  = 2;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t        state, state_next;
  logic          load_use;
  logic          capture;
  logic [DW-1:0] fwd_rs, fwd_rt;

  // Operand resolution for one source register; first match wins.
  function automatic logic [DW-1:0] fwd(input logic [RW-1:0] src,
                                        input logic [DW-1:0] rf_data);
    if (src == '0)
      return '0;
    else if (out_valid && out_ctrl[CTRL_REG_WRITE] && !out_ctrl[CTRL_MEM_READ]
             && out_rd == src)
      return ex_result;
    else if (mem_reg_write && mem_rd == src)
      return mem_data;
    else
      return rf_data;
  endfunction

  // Hazard detection and handshake: a load in EX cannot feed the next
  // instruction yet, so it must wait one cycle for the MEM-stage value.
  always_comb begin
    load_use = out_valid && out_ctrl[CTRL_REG_WRITE] && out_ctrl[CTRL_MEM_READ]
               && (out_rd != '0) && ((out_rd == in_rs) || (out_rd == in_rt));
    in_ready = !flush && !load_use && (!out_valid || ex_ready);
    capture  = in_valid && in_ready;
    fwd_rs   = fwd(in_rs, in_rs_data);
    fwd_rt   = fwd(in_rt, in_rt_data);
  end

  // State register: EMPTY/FULL mirrors out_valid.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    if (reset) state <= EMPTY;
    else       state <= state_next;
  end

  // Next-state logic: flush beats capture, capture beats drain, else hold.
  always_comb begin
    // NOTE: default first so every path assigns state_next and no latch forms.
    state_next = state;
    if (flush)         state_next = EMPTY;
    else if (capture)  state_next = FULL;
    else if (ex_ready) state_next = EMPTY;
  end

  // Output logic for the FSM.
  always_comb begin
    out_valid = (state == FULL);
  end

  // Payload register: loads resolved operands on capture, otherwise holds.
  always_ff @(posedge clk) begin
    // NOTE: the payload is cleared on reset so outputs are a known zero after
    // reset, not just don't-care behind out_valid=0.
    if (reset) begin
      out_a           <= '0;
      out_b           <= '0;
      out_alu_control <= '0;
      out_store_data  <= '0;
      out_rd          <= '0;
      out_ctrl        <= '0;
    end else if (capture) begin
      out_a           <= fwd_rs;
      out_b           <= in_alu_src ? in_imm : fwd_rt;
      out_alu_control <= in_alu_control;
      out_store_data  <= fwd_rt;
      out_rd          <= in_rd;
      out_ctrl        <= in_ctrl;
    end
  end

`ifdef ID_EX_STALL_CNT_EN
  // Saturating count of cycles a valid instruction is blocked by load-use.
  always_ff @(posedge clk) begin
    if (reset)
      stall_count <= '0;
    else if (in_valid && load_use && !flush && stall_count != 16'hFFFF)
      stall_count <= stall_count + 16'd1;
  end
`endif

endmodule
